pipe_hazard_ctrl: RTL and testbench

//  Parametrised hazard unit for the 5-stage MIPS pipeline: merges bypass selection, load-use stalls,

---
 rtl/pipe_hazard_ctrl_pkg.sv | 16 +
 rtl/pipe_hazard_ctrl_fwd_sel.sv | 40 ++++
 rtl/pipe_hazard_ctrl.sv | 156 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard unit: bypass select codes and stall-FSM states.
package pipe_hazard_ctrl_pkg;

  localparam logic [1:0] BYP_REGF  = 2'b00;
  localparam logic [1:0] BYP_MEMWB = 2'b01;
  localparam logic [1:0] BYP_EXMEM = 2'b10;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    HZ_RUN    = 2'b00,
    HZ_LSTALL = 2'b01,
    HZ_MULTI  = 2'b10
  } hz_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// One source register against the EX, MEM and WB destinations: bypass select
// (youngest producer wins) plus a flag for any pending write to that source.
module pipe_hazard_ctrl_fwd_sel
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic              use_src,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_we,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_we,
  output logic [1:0]        sel,
  output logic              raw
);

  logic live;
  logic ex_hit;
  logic mem_hit;
  logic wb_hit;

  // r0 is hard-wired to zero, so it never depends on an in-flight producer.
  assign live    = use_src && (src != '0);
  assign ex_hit  = live && ex_we  && (ex_rd  == src);
  assign mem_hit = live && mem_we && (mem_rd == src);
  assign wb_hit  = live && wb_we  && (wb_rd  == src);

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
  always_comb begin
    sel = BYP_REGF;
    if (mem_hit)     sel = BYP_EXMEM;
    else if (wb_hit) sel = BYP_MEMWB;
  end

  assign raw = ex_hit | mem_hit | wb_hit;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard unit for the 5-stage pipeline: operand bypass, load-use stalls,
// multi-cycle EX hold and taken-branch flush, sequenced by a small stall FSM.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW    = 5,
  parameter int LOAD_LAT  = 1,
  parameter int MUL_LAT   = 4,
  parameter int BYPASS_EN = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [REG_AW-1:0] ifid_rs,
  input  logic [REG_AW-1:0] ifid_rt,
  input  logic              ifid_use_rs,
  input  logic              ifid_use_rt,
  input  logic [REG_AW-1:0] idex_rs,
  input  logic [REG_AW-1:0] idex_rt,
  input  logic [REG_AW-1:0] idex_rd,
  input  logic              idex_regwrite,
  input  logic              idex_memread,
  input  logic              idex_multi,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic              exmem_regwrite,
  input  logic              memwb_regwrite,
  input  logic              branch_taken,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              ex_hold,
  output logic [1:0]        bypassA,
  output logic [1:0]        bypassB
);

  localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(LOAD_LAT - 2);
  localparam logic [CNT_W-1:0] MUL_CNT  = CNT_W'(MUL_LAT - 2);

  hz_state_t        state;
  logic [CNT_W-1:0] cnt;

  logic [1:0] sel_a, sel_b, sel_irs, sel_irt;
  logic       raw_a, raw_b, raw_irs, raw_irt;
  logic       load_use;
  logic       raw_stall;
  logic       unused_sigs;

  // EX-side operands only need the MEM/WB select; the EX slot is disabled.
  pipe_hazard_ctrl_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .src(idex_rs), .use_src(1'b1), .ex_rd('0), .ex_we(1'b0),
    .mem_rd(exmem_rd), .mem_we(exmem_regwrite), .wb_rd(memwb_rd), .wb_we(memwb_regwrite),
    .sel(sel_a), .raw(raw_a)
  );

  pipe_hazard_ctrl_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .src(idex_rt), .use_src(1'b1), .ex_rd('0), .ex_we(1'b0),
    .mem_rd(exmem_rd), .mem_we(exmem_regwrite), .wb_rd(memwb_rd), .wb_we(memwb_regwrite),
    .sel(sel_b), .raw(raw_b)
  );

  // ID-side sources check every producer still in flight, for the no-bypass stall.
  pipe_hazard_ctrl_fwd_sel #(.REG_AW(REG_AW)) u_raw_rs (
    .src(ifid_rs), .use_src(ifid_use_rs), .ex_rd(idex_rd), .ex_we(idex_regwrite),
    .mem_rd(exmem_rd), .mem_we(exmem_regwrite), .wb_rd(memwb_rd), .wb_we(memwb_regwrite),
    .sel(sel_irs), .raw(raw_irs)
  );

  pipe_hazard_ctrl_fwd_sel #(.REG_AW(REG_AW)) u_raw_rt (
    .src(ifid_rt), .use_src(ifid_use_rt), .ex_rd(idex_rd), .ex_we(idex_regwrite),
    .mem_rd(exmem_rd), .mem_we(exmem_regwrite), .wb_rd(memwb_rd), .wb_we(memwb_regwrite),
    .sel(sel_irt), .raw(raw_irt)
  );

  assign unused_sigs = ^{raw_a, raw_b, sel_irs, sel_irt};

  assign load_use  = idex_memread && (idex_rd != '0) &&
                     ((ifid_use_rs && (ifid_rs == idex_rd)) ||
                      (ifid_use_rt && (ifid_rt == idex_rd)));
  assign raw_stall = (BYPASS_EN == 0) && (raw_irs || raw_irt);

  // NOTE: sequential state is written only with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= HZ_RUN;
      cnt   <= '0;
    end else begin
      unique case (state)
        HZ_RUN: begin
          if (!branch_taken) begin
            if (idex_multi) begin
              if (MUL_LAT > 2) begin
                state <= HZ_MULTI;
                cnt   <= MUL_CNT;
              end
            end else if (load_use && (LOAD_LAT > 1)) begin
              state <= HZ_LSTALL;
              cnt   <= LOAD_CNT;
            end
          end
        end
        HZ_LSTALL: begin
          if (cnt == '0) state <= HZ_RUN;
          else           cnt   <= cnt - 4'd1;
        end
        // The RUN cycle that saw idex_multi already held once, so leave on cnt==1.
        HZ_MULTI: begin
          if (cnt <= 4'd1) begin
            state <= HZ_RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= HZ_RUN;
      endcase
    end
  end

  always_comb begin
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    ex_hold     = 1'b0;
    bypassA     = (BYPASS_EN != 0) ? sel_a : BYP_REGF;
    bypassB     = (BYPASS_EN != 0) ? sel_b : BYP_REGF;
    if (!reset) begin
      idex_bubble = 1'b1;
      bypassA     = BYP_REGF;
      bypassB     = BYP_REGF;
    end else begin
      unique case (state)
        HZ_RUN: begin
          if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
          end else if (idex_multi) begin
            ex_hold = 1'b1;
          end else if (load_use || raw_stall) begin
            idex_bubble = 1'b1;
          end else begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
          end
        end
        HZ_LSTALL: idex_bubble = 1'b1;
        HZ_MULTI:  ex_hold     = 1'b1;
        default:   idex_bubble = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Drives two hazard units (bypass on / bypass off, different latencies) with shared
// stimulus and scores their outputs against a remaining-cycles reference model.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic       rst_n;
    logic [4:0] ifid_rs;
    logic [4:0] ifid_rt;
    logic       use_rs;
    logic       use_rt;
    logic [4:0] idex_rs;
    logic [4:0] idex_rt;
    logic [4:0] idex_rd;
    logic       idex_regwrite;
    logic       idex_memread;
    logic       idex_multi;
    logic [4:0] exmem_rd;
    logic [4:0] memwb_rd;
    logic       exmem_regwrite;
    logic       memwb_regwrite;
    logic       branch_taken;
  } stim_t;

  typedef struct packed {
    logic       pc_write;
    logic       ifid_write;
    logic       ifid_flush;
    logic       idex_bubble;
    logic       ex_hold;
    logic [1:0] byp_a;
    logic [1:0] byp_b;
  } outs_t;

  typedef struct {
    outs_t exp;
    outs_t care;
    int    cyc;
  } exp_t;

  localparam int LL0 = 2, ML0 = 4, BE0 = 1;
  localparam int LL1 = 3, ML1 = 5, BE1 = 0;

  logic       clk;
  logic       rst_n;
  logic [4:0] ifid_rs, ifid_rt, idex_rs, idex_rt, idex_rd, exmem_rd, memwb_rd;
  logic       ifid_use_rs, ifid_use_rt, idex_regwrite, idex_memread, idex_multi;
  logic       exmem_regwrite, memwb_regwrite, branch_taken;

  logic       pc_write_0, ifid_write_0, ifid_flush_0, idex_bubble_0, ex_hold_0;
  logic [1:0] bypassA_0, bypassB_0;
  logic       pc_write_1, ifid_write_1, ifid_flush_1, idex_bubble_1, ex_hold_1;
  logic [1:0] bypassA_1, bypassB_1;
  outs_t      act0, act1;

  exp_t q0[$];
  exp_t q1[$];
  int   st[2];
  int   hd[2];
  int   cyc;
  int   checks;
  int   errors;

  pipe_hazard_ctrl #(.REG_AW(5), .LOAD_LAT(LL0), .MUL_LAT(ML0), .BYPASS_EN(BE0)) dut0 (
    .clock(clk), .reset(rst_n),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_use_rs(ifid_use_rs), .ifid_use_rt(ifid_use_rt),
    .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_rd(idex_rd),
    .idex_regwrite(idex_regwrite), .idex_memread(idex_memread), .idex_multi(idex_multi),
    .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
    .exmem_regwrite(exmem_regwrite), .memwb_regwrite(memwb_regwrite),
    .branch_taken(branch_taken),
    .pc_write(pc_write_0), .ifid_write(ifid_write_0), .ifid_flush(ifid_flush_0),
    .idex_bubble(idex_bubble_0), .ex_hold(ex_hold_0),
    .bypassA(bypassA_0), .bypassB(bypassB_0)
  );

  pipe_hazard_ctrl #(.REG_AW(5), .LOAD_LAT(LL1), .MUL_LAT(ML1), .BYPASS_EN(BE1)) dut1 (
    .clock(clk), .reset(rst_n),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_use_rs(ifid_use_rs), .ifid_use_rt(ifid_use_rt),
    .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_rd(idex_rd),
    .idex_regwrite(idex_regwrite), .idex_memread(idex_memread), .idex_multi(idex_multi),
    .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
    .exmem_regwrite(exmem_regwrite), .memwb_regwrite(memwb_regwrite),
    .branch_taken(branch_taken),
    .pc_write(pc_write_1), .ifid_write(ifid_write_1), .ifid_flush(ifid_flush_1),
    .idex_bubble(idex_bubble_1), .ex_hold(ex_hold_1),
    .bypassA(bypassA_1), .bypassB(bypassB_1)
  );

  assign act0 = {pc_write_0, ifid_write_0, ifid_flush_0, idex_bubble_0, ex_hold_0, bypassA_0, bypassB_0};
  assign act1 = {pc_write_1, ifid_write_1, ifid_flush_1, idex_bubble_1, ex_hold_1, bypassA_1, bypassB_1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] byp(input logic [4:0] src, input stim_t s);
    if (src == 5'd0)                                return 2'b00;
    if (s.exmem_regwrite && (s.exmem_rd == src))    return 2'b10;
    if (s.memwb_regwrite && (s.memwb_rd == src))    return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit pending(input logic [4:0] src, input bit used, input stim_t s);
    if (!used || (src == 5'd0)) return 1'b0;
    return (s.idex_regwrite  && (s.idex_rd  == src)) ||
           (s.exmem_regwrite && (s.exmem_rd == src)) ||
           (s.memwb_regwrite && (s.memwb_rd == src));
  endfunction

  // Reference: st = stall cycles still owed, hd = extra hold cycles still owed.
  function automatic void model(input stim_t s, input int ll, input int ml, input int be,
                                inout int st_r, inout int hd_r,
                                output outs_t e, output outs_t care);
    bit lu;
    care = '1;
    e    = '0;
    if (!s.rst_n) begin
      st_r          = 0;
      hd_r          = 0;
      e.idex_bubble = 1'b1;
      return;
    end
    if (be != 0) begin
      e.byp_a = byp(s.idex_rs, s);
      e.byp_b = byp(s.idex_rt, s);
    end
    lu = s.idex_memread && (s.idex_rd != 5'd0) &&
         ((s.use_rs && (s.ifid_rs == s.idex_rd)) || (s.use_rt && (s.ifid_rt == s.idex_rd)));
    if (hd_r > 0) begin
      e.ex_hold        = 1'b1;
      care.idex_bubble = 1'b0;
      hd_r--;
    end else if (st_r > 0) begin
      e.idex_bubble = 1'b1;
      st_r--;
    end else if (s.branch_taken) begin
      e.ifid_flush    = 1'b1;
      e.idex_bubble   = 1'b1;
      e.pc_write      = 1'b1;
      care.ifid_write = 1'b0;
    end else if (s.idex_multi) begin
      e.ex_hold        = 1'b1;
      care.idex_bubble = 1'b0;
      hd_r             = ml - 2;
    end else if (lu) begin
      e.idex_bubble = 1'b1;
      st_r          = ll - 1;
    end else if ((be == 0) && (pending(s.ifid_rs, s.use_rs, s) || pending(s.ifid_rt, s.use_rt, s))) begin
      e.idex_bubble = 1'b1;
    end else begin
      e.pc_write   = 1'b1;
      e.ifid_write = 1'b1;
    end
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s       = '0;
    s.rst_n = 1'b1;
    return s;
  endfunction

  task automatic step(input stim_t s);
    exp_t  x;
    int    a, b;
    @(posedge clk);
    #1;
    rst_n          = s.rst_n;
    ifid_rs        = s.ifid_rs;
    ifid_rt        = s.ifid_rt;
    ifid_use_rs    = s.use_rs;
    ifid_use_rt    = s.use_rt;
    idex_rs        = s.idex_rs;
    idex_rt        = s.idex_rt;
    idex_rd        = s.idex_rd;
    idex_regwrite  = s.idex_regwrite;
    idex_memread   = s.idex_memread;
    idex_multi     = s.idex_multi;
    exmem_rd       = s.exmem_rd;
    memwb_rd       = s.memwb_rd;
    exmem_regwrite = s.exmem_regwrite;
    memwb_regwrite = s.memwb_regwrite;
    branch_taken   = s.branch_taken;
    x.cyc = cyc;
    a = st[0]; b = hd[0];
    model(s, LL0, ML0, BE0, a, b, x.exp, x.care);
    st[0] = a; hd[0] = b;
    q0.push_back(x);
    a = st[1]; b = hd[1];
    model(s, LL1, ML1, BE1, a, b, x.exp, x.care);
    st[1] = a; hd[1] = b;
    q1.push_back(x);
    cyc++;
  endtask

  task automatic compare(input int id, input exp_t x, input outs_t act);
    checks++;
    if (((act ^ x.exp) & x.care) != '0) begin
      errors++;
      $display("FAIL outputs dut%0d cycle %0d: got %b expected %b (care %b)",
               id, x.cyc, act, x.exp, x.care);
    end
  endtask

  // Monitor: every cycle the DUTs present a full output set; score it mid-cycle.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (q0.size() != 0) begin
        x = q0.pop_front();
        compare(0, x, act0);
      end
      if (q1.size() != 0) begin
        x = q1.pop_front();
        compare(1, x, act1);
      end
    end
  end

  initial begin
    stim_t s;
    checks = 0;
    errors = 0;
    cyc    = 0;
    st[0] = 0; st[1] = 0; hd[0] = 0; hd[1] = 0;
    s = idle();
    s.rst_n = 1'b0;
    for (int i = 0; i < 3; i++) step(s);

    // Bypass priority and r0 exclusion.
    s = idle();
    s.exmem_rd = 5'd3; s.memwb_rd = 5'd3; s.idex_rs = 5'd3;
    s.exmem_regwrite = 1'b1; s.memwb_regwrite = 1'b1;
    step(s);
    s.exmem_regwrite = 1'b0;
    step(s);
    s.idex_rs = 5'd0;
    step(s);

    // Load-use hazard.
    s = idle();
    s.idex_memread = 1'b1; s.idex_regwrite = 1'b1; s.idex_rd = 5'd5;
    s.ifid_rs = 5'd5; s.use_rs = 1'b1;
    step(s);
    for (int i = 0; i < 4; i++) step(idle());

    // Multi-cycle EX hold.
    s = idle();
    s.idex_multi = 1'b1;
    step(s);
    for (int i = 0; i < 5; i++) step(idle());

    // Branch flush beats a simultaneous load-use match.
    s = idle();
    s.branch_taken = 1'b1;
    s.idex_memread = 1'b1; s.idex_rd = 5'd5; s.ifid_rs = 5'd5; s.use_rs = 1'b1;
    step(s);
    for (int i = 0; i < 4; i++) step(idle());

    // No-bypass RAW stall from WB, then the same with rt unused.
    s = idle();
    s.memwb_rd = 5'd7; s.memwb_regwrite = 1'b1; s.ifid_rt = 5'd7; s.use_rt = 1'b1;
    step(s);
    s.use_rt = 1'b0;
    step(s);

    // Reset aborts a multi-cycle hold.
    s = idle();
    s.idex_multi = 1'b1;
    step(s);
    step(idle());
    s = idle();
    s.rst_n = 1'b0;
    step(s);
    for (int i = 0; i < 4; i++) step(idle());

    // Randomised traffic on a small register range to provoke collisions.
    for (int n = 0; n < 1500; n++) begin
      s = idle();
      s.rst_n          = ($urandom_range(0, 59) != 0);
      s.ifid_rs        = 5'($urandom_range(0, 7));
      s.ifid_rt        = 5'($urandom_range(0, 7));
      s.use_rs         = 1'($urandom_range(0, 1));
      s.use_rt         = 1'($urandom_range(0, 1));
      s.idex_rs        = 5'($urandom_range(0, 7));
      s.idex_rt        = 5'($urandom_range(0, 7));
      s.idex_rd        = 5'($urandom_range(0, 7));
      s.idex_regwrite  = 1'($urandom_range(0, 1));
      s.idex_memread   = ($urandom_range(0, 2) == 0);
      s.idex_multi     = ($urandom_range(0, 11) == 0);
      s.exmem_rd       = 5'($urandom_range(0, 7));
      s.memwb_rd       = 5'($urandom_range(0, 7));
      s.exmem_regwrite = 1'($urandom_range(0, 1));
      s.memwb_regwrite = 1'($urandom_range(0, 1));
      // A taken branch can only resolve while EX holds a real instruction.
      s.branch_taken   = (st[0] == 0) && (hd[0] == 0) && (st[1] == 0) && (hd[1] == 0) &&
                         ($urandom_range(0, 7) == 0);
      step(s);
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if ((q0.size() + q1.size()) != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q0.size() + q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
